// File: rtl/ccff_bitstream_loader.sv
`timescale 1ns/1ps
// Serializes exactly CHAIN_LEN configuration bits from a word stream onto ccff_head,
// then checks a trailer word against a CRC-8 (poly 0x07, LSB-first) of those bits.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              crc_err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);
  localparam int BW = ((CW > WW) ? CW : WW) + 1;
  localparam logic [BW-1:0] LEN_B  = BW'(CHAIN_LEN);
  localparam logic [BW-1:0] WORD_B = BW'(WORD_W);
  localparam logic [BW-1:0] ONE_B  = BW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
  state_t state_q, state_d;

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     wbits_q, wbits_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [7:0]        crc_q, crc_d;
  logic              crc_err_q, crc_err_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;

  logic          shifting, last_bit, accept, begin_load, fb;
  logic [BW-1:0] remaining;
  logic [7:0]    crc_shift;

  // remaining = bits neither issued nor already sitting in shreg
  assign remaining  = LEN_B - cnt_q - wbits_q;
  assign shifting   = (state_q == S_LOAD) && (wbits_q != '0);
  assign last_bit   = shifting && ((cnt_q + ONE_B) == LEN_B);
  assign accept     = s_valid && s_ready;
  assign begin_load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start)    state_d = S_LOAD;
        S_LOAD:         if (last_bit) state_d = S_CHECK;
        S_CHECK:        if (accept)   state_d = S_DONE;
        default:                      state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_LOAD: begin
        // wbits==1 implies a shift this cycle, so the next word lands without a bubble
        s_ready = (wbits_q <= ONE_B) && (remaining != '0);
        busy    = 1'b1;
      end
      S_CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    wbits_d    = wbits_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    crc_err_d  = crc_err_q;
    head_d     = head_q;
    shift_en_d = 1'b0;
    fb         = crc_q[7] ^ shreg_q[0];
    crc_shift  = {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    if (abort) begin
      wbits_d   = '0;
      crc_err_d = 1'b0;
    end else if (begin_load) begin
      cnt_d     = '0;
      crc_d     = '0;
      crc_err_d = 1'b0;
      wbits_d   = '0;
    end else begin
      if (shifting) begin
        head_d     = shreg_q[0];
        shift_en_d = 1'b1;
        shreg_d    = shreg_q >> 1;
        wbits_d    = wbits_q - ONE_B;
        cnt_d      = cnt_q + ONE_B;
        crc_d      = crc_shift;
      end
      if (accept && (state_q == S_LOAD)) begin
        shreg_d = s_data;
        wbits_d = (remaining > WORD_B) ? WORD_B : remaining;
      end
      if (accept && (state_q == S_CHECK)) begin
        crc_err_d = (s_data[7:0] != crc_q);
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shreg_q    <= '0;
      wbits_q    <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      crc_err_q  <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      wbits_q    <= wbits_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      crc_err_q  <= crc_err_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign crc_err       = crc_err_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
`timescale 1ns/1ps
// Directed bench for ccff_bitstream_loader: a CHAIN_LEN=20 instance for load/stall/CRC/
// abort/reset/restart cases and a CHAIN_LEN=16 instance for word-aligned payloads.
module tb_ccff_bitstream_loader;
  logic       prog_clk;
  logic       prog_rst_n;
  logic       start, abort, s_valid, s_ready;
  logic [7:0] s_data;
  logic       ccff_head, ccff_shift_en, busy, done, crc_err;

  logic       start16, abort16, s_valid16, s_ready16;
  logic [7:0] s_data16;
  logic       head16, shift_en16, busy16, done16, crc_err16;

  int n_cmp = 0;
  int n_err = 0;
  int en20 = 0;
  int en16 = 0;
  logic cap20 [512];
  logic cap16 [512];

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .busy(busy), .done(done), .crc_err(crc_err)
  );

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start16), .abort(abort16),
    .s_data(s_data16), .s_valid(s_valid16), .s_ready(s_ready16), .ccff_head(head16),
    .ccff_shift_en(shift_en16), .busy(busy16), .done(done16), .crc_err(crc_err16)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Record every bit the chain would capture (enabled cycles only)
  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin
      cap20[en20] = ccff_head;
      en20++;
    end
    if (shift_en16 === 1'b1) begin
      cap16[en16] = head16;
      en16++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [7:0] crc8(input logic [31:0] bits, input int n);
    logic [7:0] c;
    logic       f;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      f = c[7] ^ bits[i];
      c = {c[6:0], 1'b0} ^ (f ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic load20(input logic [7:0] trailer, input bit stall, input bit poke_start,
                        input int abort_at, input logic exp_err);
    logic [7:0]  words [4];
    logic [19:0] got;
    logic        ok;
    int          idx, cyc, base;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F; words[3] = trailer;
    base  = en20;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ready", 32'({busy, s_ready}), 32'h3);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 300) begin
      if (abort_at >= 0 && (en20 - base) == abort_at) begin
        s_valid = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 32'({busy, done, s_ready, ccff_shift_en}), 32'h0);
        return;
      end
      if (ccff_shift_en && (en20 - base) == 19)
        check("check_entry", 32'({busy, s_ready}), 32'h3);
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = words[idx];
      start   = poke_start && (cyc == 4);
      ok      = s_valid && s_ready;
      tick();
      if (ok) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    check("accept_budget", 32'(idx), 32'd4);
    check("shift_count", 32'(en20 - base), 32'd20);
    got = '0;
    for (int i = 0; i < 20; i++) got[i] = cap20[base + i];
    check("bit_seq", 32'(got), 32'h000F3CA5);
    check("done_state", 32'({done, busy, ccff_shift_en}), 32'h4);
    check("crc_err", 32'(crc_err), 32'(exp_err));
  endtask

  task automatic load16();
    logic [7:0]  words [3];
    logic [15:0] got;
    logic        ok;
    int          idx, cyc, base;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = crc8(32'h0000_00FF, 16);
    base    = en16;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 100) begin
      if (shift_en16 && (en16 - base) == 15)
        check("align_check_entry", 32'({busy16, s_ready16}), 32'h3);
      s_valid16 = 1'b1;
      s_data16  = words[idx];
      ok        = s_ready16;
      tick();
      if (ok) idx++;
      cyc++;
    end
    s_valid16 = 1'b0;
    check("align_budget", 32'(idx), 32'd3);
    check("align_count", 32'(en16 - base), 32'd16);
    got = '0;
    for (int i = 0; i < 16; i++) got[i] = cap16[base + i];
    check("align_bits", 32'(got), 32'h0000_00FF);
    check("align_done", 32'({done16, crc_err16}), 32'h2);
  endtask

  initial begin
    logic [7:0] crc_ok;
    prog_rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    start16 = 1'b0; abort16 = 1'b0; s_valid16 = 1'b0; s_data16 = '0;
    repeat (2) @(posedge prog_clk);
    #1;
    check("reset_outs", 32'({s_ready, ccff_head, ccff_shift_en, busy, done, crc_err}), 32'h0);
    check("reset_outs16", 32'({s_ready16, head16, shift_en16, busy16, done16, crc_err16}), 32'h0);
    prog_rst_n = 1'b1;
    tick();

    crc_ok = crc8(32'h000F_3CA5, 20);
    load20(crc_ok, 1'b0, 1'b0, -1, 1'b0);          // nominal
    load20(crc_ok ^ 8'h01, 1'b0, 1'b0, -1, 1'b1);  // CRC mismatch, started from DONE
    load20(crc_ok, 1'b1, 1'b0, -1, 1'b0);          // stalls; restart clears crc_err
    load20(crc_ok, 1'b0, 1'b1, -1, 1'b0);          // start during LOAD is ignored
    load20(crc_ok, 1'b0, 1'b0, 7, 1'b0);           // abort after 7 shifts
    load20(crc_ok, 1'b0, 1'b0, -1, 1'b0);          // full load after abort

    // Asynchronous reset in the middle of a cycle during LOAD
    start = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    repeat (4) tick();
    check("pre_reset_shifting", 32'({busy, ccff_shift_en, ccff_head}), 32'h7);
    #3 prog_rst_n = 1'b0;
    #1;
    check("reset_async", 32'({s_ready, ccff_head, ccff_shift_en, busy, done, crc_err}), 32'h0);
    s_valid = 1'b0;
    tick();
    prog_rst_n = 1'b1;
    tick();
    load20(crc_ok, 1'b0, 1'b0, -1, 1'b0);

    load16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Configuration-chain loader sitting directly upstream of the CLB logical tile's `ccff_head` input. It accepts bitstream words over a valid/ready stream and serializes exactly `CHAIN_LEN` bits onto the configuration flip-flop chain, one bit per enabled shift. It drives a shift enable for the chain's external clock gate. After the payload it takes one trailer word and checks it against a CRC-8 computed over the shifted bits.

## Interface
- `WORD_W`, default 8: stream word width; must be ≥ 8.
- `CHAIN_LEN`, default 20: number of configuration bits in the downstream chain; must be ≥ 1.
- `prog_clk`, input, 1: programming clock; all state is on the rising edge.
- `prog_rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `abort`, input, 1: returns to IDLE from any state on the next edge.
- `s_data`, input, `WORD_W`: bitstream word.
- `s_valid`, input, 1: `s_data` is valid.
- `s_ready`, output, 1: loader accepts `s_data`; a transfer occurs when `s_valid` and `s_ready` are both high.
- `ccff_head`, output, 1: serial configuration bit to the chain.
- `ccff_shift_en`, output, 1: enable for the chain's `prog_clk` gate. The chain shifts at the rising edge that ends a cycle in which this signal is high.
- `busy`, output, 1: high in LOAD and CHECK.
- `done`, output, 1: high in DONE.
- `crc_err`, output, 1: result of the CRC compare; valid while `done` is high.

## Operation
- **FSM states:** IDLE, LOAD, CHECK, DONE.
- **IDLE:**
  - `s_ready` = 0.
  - `start` → LOAD; clears the bit counter, the CRC register (init 0x00) and `crc_err`.
- **LOAD:**
  - A WORD_W shift register (`shreg`) plus a count of remaining valid bits (`wbits`).
  - `s_ready` = (`wbits` == 0) or (`wbits` == 1 and a shift is occurring this cycle), so back-to-back words stream without a bubble.
  - On accept, load `shreg` = `s_data` and `wbits` = min(`WORD_W`, `CHAIN_LEN` − bits_shifted − bits_pending).
  - Bits of the final payload word beyond `CHAIN_LEN` are discarded.
  - Each cycle with `wbits` > 0:
    - registered `ccff_head` ← `shreg[0]` and `ccff_shift_en` ← 1;
    - `shreg` shifts right; `wbits` decrements;
    - the CRC absorbs the bit, LSB-first (polynomial 0x07, serial: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0)).
  - Otherwise `ccff_shift_en` ← 0 and `ccff_head` holds its value.
  - After the `CHAIN_LEN`-th bit is issued, the state goes to CHECK and `s_ready` rises the same cycle.
- **Bit order:** the first bit issued ends up deepest in the chain, at the `ccff_tail` end.
- **CHECK:**
  - `s_ready` = 1 and `ccff_shift_en` = 0.
  - On accept, `crc_err` ← (`s_data[7:0]` != crc) and the state goes to DONE.
- **DONE:**
  - `done` = 1 and `s_ready` = 0; the state holds.
  - `start` → LOAD (new load).
- **start handling:** `start` in LOAD or CHECK is ignored.
- **abort:** next state is IDLE. `ccff_shift_en` ← 0, `crc_err` ← 0, `wbits` ← 0. A partially loaded chain is left as is; the next load overwrites it completely.
- **Simultaneous `abort` and `start`:** `abort` wins.

## Timing
- **Reset values:** `s_ready` = 0, `ccff_head` = 0, `ccff_shift_en` = 0, `busy` = 0, `done` = 0, `crc_err` = 0, state = IDLE. Reset takes effect immediately and asynchronously, mid-load included.
- **Start to ready:** `start` sampled at edge E; `s_ready` is high in the cycle after E.
- **Word to chain:**
  - A word accepted at edge A has its first bit on `ccff_head`, with `ccff_shift_en` = 1, during cycle A+1.
  - The bit is captured by the chain at edge A+2.
- **Throughput:** with `s_valid` held high, exactly `CHAIN_LEN` consecutive cycles have `ccff_shift_en` = 1, with no gaps.
- **Stalls:** a `s_valid` stall produces `ccff_shift_en` = 0 cycles; no bit is lost or duplicated.
- **CHECK to DONE:** the CRC word accepted at edge C gives `done` = 1 and a valid `crc_err` in cycle C+1.
- **Count exactness:** the number of `ccff_shift_en` = 1 cycles per completed load is exactly `CHAIN_LEN`, regardless of `WORD_W` alignment.

## Test plan
- **Nominal load** (`WORD_W` = 8, `CHAIN_LEN` = 20): `start`, then words 0xA5, 0x3C, 0x0F with `s_valid` always high.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1 over 20 consecutive enabled cycles.
  - Upper nibble of 0x0F is discarded.
  - The CRC word from the bench model yields `done` = 1, `crc_err` = 0.
- **Stall tolerance:** same data with `s_valid` randomly deasserted 50% of cycles.
  - Identical enabled-bit sequence and 20 enabled cycles.
  - `done` = 1, `crc_err` = 0.
- **CRC mismatch:** nominal stream with the trailer set to model CRC ^ 0x01 → `done` = 1, `crc_err` = 1.
- **Alignment:** `CHAIN_LEN` = 16 with two words 0xFF, 0x00 → 16 enabled cycles (8 ones then 8 zeros); CHECK is entered immediately after the last shifted bit.
- **Abort and reset:**
  - `abort` after 7 enabled shifts → IDLE next cycle, `ccff_shift_en` = 0.
  - A following full load then completes correctly.
  - Separately, `prog_rst_n` low mid-LOAD → all outputs 0 immediately.
- **Ignored start / restart:**
  - `start` pulsed during LOAD causes no restart: the enabled-bit count is still 20.
  - `start` in DONE starts a second load, which completes with `crc_err` evaluated afresh.
